// File: rtl/sdram_pkg.sv
// Shared types, widths and helpers for the SDRAM write path.
// Addresses are {bank, row, col}; a burst never crosses a row.
package sdram_pkg;

    localparam int BANK_W    = 2;
    localparam int ROW_W     = 13;
    localparam int COL_W     = 9;
    localparam int ADDR_W    = BANK_W + ROW_W + COL_W;
    localparam int DATA_W    = 16;
    localparam int BST_LEN_W = 10;

    // Write-buffer FSM state encoding.
    typedef logic [1:0] wr_state_t;
    localparam wr_state_t ST_IDLE = 2'd0;
    localparam wr_state_t ST_REQ  = 2'd1;
    localparam wr_state_t ST_XFER = 2'd2;
    localparam wr_state_t ST_DONE = 2'd3;

    function automatic logic [BANK_W-1:0] addr_bank(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: BANK_W];
    endfunction

    function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] addr);
        return addr[COL_W +: ROW_W];
    endfunction

    function automatic logic [COL_W-1:0] addr_col(input logic [ADDR_W-1:0] addr);
        return addr[COL_W-1:0];
    endfunction

    // Advance one burst slot; wrap to base when the next slot would run past last.
    function automatic logic [ADDR_W-1:0] next_burst_addr(
        input logic [ADDR_W-1:0] cur,
        input logic [ADDR_W-1:0] step,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] last
    );
        logic [ADDR_W:0] nxt;
        logic [ADDR_W:0] nxt_end;
        nxt     = {1'b0, cur} + {1'b0, step};
        nxt_end = nxt + {1'b0, step} - (ADDR_W + 1)'(1);
        if (nxt_end > {1'b0, last}) begin
            return base;
        end
        return nxt[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/sdram_wr_buf_if.sv
// Bundle of the user-stream and write-stage signals around sdram_wr_buf.
// master = the buffer itself, slave = user source plus write stage.
interface sdram_wr_buf_if #(
    parameter int DEPTH = 1024
);
    import sdram_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;

    // User stream: a word moves on a clock edge where usr_wr_valid && usr_wr_ready;
    // the source holds usr_wr_data stable while valid is high and ready is low.
    logic                 usr_wr_valid;
    logic [DATA_W-1:0]    usr_wr_data;
    logic                 usr_wr_ready;
    logic                 usr_flush;
    logic [LW-1:0]        usr_level;

    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [BST_LEN_W-1:0] wr_bst_len;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_ack;
    logic                 wr_end;

    logic                 busy;
    logic                 err_underrun;
    wr_state_t            dbg_state;

    modport master (
        input  usr_wr_valid, usr_wr_data, usr_flush, wr_ack, wr_end,
        output usr_wr_ready, usr_level, wr_en, wr_addr, wr_bst_len, wr_data,
               busy, err_underrun, dbg_state
    );

    modport slave (
        output usr_wr_valid, usr_wr_data, usr_flush, wr_ack, wr_end,
        input  usr_wr_ready, usr_level, wr_en, wr_addr, wr_bst_len, wr_data,
               busy, err_underrun, dbg_state
    );

endinterface

// File: rtl/sdram_sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and a
// registered not-full flag that rises one cycle after reset release.
module sdram_sync_fifo #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [LW-1:0]     level,
    output logic              ready,
    output logic              empty
);

    localparam logic [LW-1:0] FULL_LV = LW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level_nxt;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level == '0);
    assign do_push = push && ready;
    assign do_pop  = pop && !empty;

    always_comb begin
        level_nxt = level;
        case ({do_push, do_pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ready   <= 1'b0;
            rd_data <= '0;
        end else begin
            level <= level_nxt;
            ready <= (level_nxt != FULL_LV);
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: rtl/sdram_wr_buf.sv
// Write buffer feeding the SDRAM write-command stage: collects user words and
// issues full bursts (or a short burst on flush) to a wrapping address ring.
module sdram_wr_buf
    import sdram_pkg::*;
#(
    parameter int               DEPTH     = 1024,
    parameter int               BST_LEN   = 256,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 24'h000000,
    parameter logic [ADDR_W-1:0] ADDR_END  = 24'hFFFFFF
) (
    input logic              wr_clk,
    input logic              wr_rst_n,
    sdram_wr_buf_if.master   bus
);

    localparam int                   LW         = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]        BST_LEN_LV = LW'(BST_LEN);
    localparam logic [BST_LEN_W-1:0] BST_LEN_BL = BST_LEN_W'(BST_LEN);
    localparam logic [ADDR_W-1:0]    BST_STEP   = ADDR_W'(BST_LEN);

    wr_state_t            state;
    logic                 wr_en_q;
    logic                 busy_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [BST_LEN_W-1:0] bst_len_q;
    logic [BST_LEN_W-1:0] ack_cnt;
    logic [BST_LEN_W-1:0] ack_sum;
    logic                 flush_pend;
    logic                 err_q;

    logic [DATA_W-1:0]    fifo_rd_data;
    logic [LW-1:0]        fifo_level;
    logic                 fifo_ready;
    logic                 fifo_empty;

    sdram_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (wr_clk),
        .rst_n     (wr_rst_n),
        .push      (bus.usr_wr_valid),
        .push_data (bus.usr_wr_data),
        .pop       (bus.wr_ack),
        .rd_data   (fifo_rd_data),
        .level     (fifo_level),
        .ready     (fifo_ready),
        .empty     (fifo_empty)
    );

    // Acks counted so far including the one (if any) arriving this cycle.
    assign ack_sum = ack_cnt + BST_LEN_W'(bus.wr_ack);

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state      <= ST_IDLE;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= ADDR_BASE;
            bst_len_q  <= BST_LEN_BL;
            ack_cnt    <= '0;
            flush_pend <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (bus.wr_ack && fifo_empty) begin
                err_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    ack_cnt <= '0;
                    if (fifo_level >= BST_LEN_LV) begin
                        bst_len_q <= BST_LEN_BL;
                        wr_en_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= ST_REQ;
                    end else if (flush_pend && fifo_level != '0) begin
                        bst_len_q  <= BST_LEN_W'(fifo_level);
                        flush_pend <= 1'b0;
                        wr_en_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= ST_REQ;
                    end else if (flush_pend) begin
                        flush_pend <= 1'b0;
                    end
                end

                ST_REQ: begin
                    if (bus.wr_end) begin
                        wr_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= ST_DONE;
                        if (ack_sum != bst_len_q) begin
                            err_q <= 1'b1;
                        end
                    end else if (bus.wr_ack) begin
                        ack_cnt <= BST_LEN_W'(1);
                        state   <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (bus.wr_ack) begin
                        ack_cnt <= ack_sum;
                    end
                    // Drop wr_en on the wr_end edge so the write stage never sees it stale.
                    if (bus.wr_end) begin
                        wr_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= ST_DONE;
                        if (ack_sum != bst_len_q) begin
                            err_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    // Advance a full slot even after a short burst to keep alignment.
                    addr_q <= next_burst_addr(addr_q, BST_STEP, ADDR_BASE, ADDR_END);
                    state  <= ST_IDLE;
                end
            endcase

            // A new flush request wins over a same-cycle clear.
            if (bus.usr_flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    assign bus.usr_wr_ready = fifo_ready;
    assign bus.usr_level    = fifo_level;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = addr_q;
    assign bus.wr_bst_len   = bst_len_q;
    assign bus.wr_data      = fifo_rd_data;
    assign bus.busy         = busy_q;
    assign bus.err_underrun = err_q;
    assign bus.dbg_state    = state;

endmodule
